// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit: operation encodings and queue depth.
package logic_unit_pkg;

  // Operation select encodings presented on the op port.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Number of results the output queue can hold.
  localparam int QUEUE_DEPTH = 2;

endpackage : logic_unit_pkg

// File: rtl/bitwise_op.sv
// Purely combinational bitwise operator selected by op.
import logic_unit_pkg::*;

module bitwise_op #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  // Select one of the four bitwise functions across all WIDTH bits.
  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule : bitwise_op

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a 2-entry in-order result queue and
// valid/ready handshakes on both sides. in_ready depends only on the
// registered count, so there is no combinational path from out_ready.
import logic_unit_pkg::*;

module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] mem_q [QUEUE_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  bitwise_op #(.WIDTH(WIDTH)) u_bitwise_op (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (op_result)
  );

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];
  // Mask the head entry so nothing stale is visible while empty.
  assign result    = out_valid ? head : '0;
  assign zero      = out_valid && (head == '0);

  // Next-state for occupancy and 1-bit wrapping pointers.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset wins over any concurrent handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Result storage; contents are qualified by count so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= op_result;
    end
  end

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=32): directed vector table,
// hand-written backpressure/reset sequences, and randomized stress against
// a queue-based reference model.
module tb_logic_unit_pipe;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_q [$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp_result;
    logic         exp_zero;
  } vec_t;

  vec_t vecs [8];

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Compare every output against what the model queue implies.
  task automatic check_model(input string nm);
    logic [W-1:0] exp_res;
    exp_res = (model_q.size() != 0) ? model_q[0] : '0;
    chk({nm, "_out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    chk({nm, "_in_ready"},  64'(in_ready),  64'(model_q.size() < 2));
    chk({nm, "_result"},    64'(result),    64'(exp_res));
    chk({nm, "_zero"},      64'(zero),      64'((model_q.size() != 0) && (exp_res == '0)));
  endtask

  task automatic check_empty(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_in_ready"},  64'(in_ready),  64'(1));
    chk({nm, "_result"},    64'(result),    64'(0));
    chk({nm, "_zero"},      64'(zero),      64'(0));
  endtask

  initial begin
    int accepted;
    int cycles;
    bit do_push, do_pop;
    logic [W-1:0] pushed_val;

    vecs[0] = '{32'hF0F0F0F0, 32'h0FF00FF0, 2'b01, 32'hFFF0FFF0, 1'b0};
    vecs[1] = '{32'hFFFF0000, 32'hFF00FF00, 2'b00, 32'hFF000000, 1'b0};
    vecs[2] = '{32'hFFFF0000, 32'hFF00FF00, 2'b01, 32'hFFFFFF00, 1'b0};
    vecs[3] = '{32'hFFFF0000, 32'hFF00FF00, 2'b10, 32'h00FFFF00, 1'b0};
    vecs[4] = '{32'hFFFF0000, 32'hFF00FF00, 2'b11, 32'h000000FF, 1'b0};
    vecs[5] = '{32'h12345678, 32'h12345678, 2'b10, 32'h00000000, 1'b1};
    vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 2'b11, 32'h00000000, 1'b1};
    vecs[7] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 2'b01, 32'hFFFFFFFF, 1'b0};

    // Reset with a handshake pending: nothing must be recorded.
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'hDEADBEEF; b = 32'h0; op = 2'b01;
    step();
    step();
    check_empty("reset");
    reset = 1'b0; in_valid = 1'b0;
    step();
    check_empty("post_reset");

    // Table-driven back-to-back stream with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; op = vecs[i].op;
      step();
      $display("vec %0d: a=%h b=%h op=%0d -> result=%h zero=%0b", i, vecs[i].a,
               vecs[i].b, vecs[i].op, result, zero);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].exp_result));
      chk($sformatf("vec%0d_zero", i), 64'(zero), 64'(vecs[i].exp_zero));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(1));
    end
    in_valid = 1'b0;
    step();
    check_empty("drain");

    // Backpressure: AND, OR, XOR of 1 and 3 with the sink stalled.
    out_ready = 1'b0; a = 32'd1; b = 32'd3;
    in_valid = 1'b1; op = 2'b00;
    step();
    chk("bp1_in_ready", 64'(in_ready), 64'(1));
    chk("bp1_result", 64'(result), 64'(1));
    op = 2'b01;
    step();
    chk("bp2_in_ready", 64'(in_ready), 64'(0));
    chk("bp2_result_hold", 64'(result), 64'(1));
    op = 2'b10;
    step();
    chk("bp3_in_ready", 64'(in_ready), 64'(0));
    chk("bp3_result_hold", 64'(result), 64'(1));
    chk("bp3_out_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    step();
    $display("bp pop: result=%h", result);
    chk("bp4_result", 64'(result), 64'(3));
    chk("bp4_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    $display("bp pop: result=%h", result);
    chk("bp5_result", 64'(result), 64'(2));
    chk("bp5_out_valid", 64'(out_valid), 64'(1));
    step();
    check_empty("bp_drain");

    // Reset mid-stream with two results queued.
    out_ready = 1'b0; in_valid = 1'b1; a = 32'h0000FFFF; b = 32'h00FF00FF; op = 2'b00;
    step();
    step();
    chk("mrst_full_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b1; out_ready = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check_empty("mrst");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst_stale%0d", i), 64'(out_valid), 64'(0));
    end

    // Randomized stress against the reference queue.
    model_q.delete();
    accepted = 0;
    cycles = 0;
    while (accepted < 10000 && cycles < 60000) begin
      check_model("rnd");
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a  = $urandom();
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom();
      op = 2'($urandom_range(0, 3));
      do_push = in_valid && (model_q.size() < 2);
      do_pop  = out_ready && (model_q.size() != 0);
      pushed_val = ref_op(a, b, op);
      if (do_pop)
        $display("rnd out: result=%h zero=%0b", result, zero);
      step();
      cycles++;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(pushed_val);
        accepted++;
      end
    end
    chk("rnd_timeout", 64'(accepted >= 10000), 64'(1));
    check_model("rnd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_logic_unit_pipe

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset sampled on the clock rising edge.
REQ-004 The block SHALL have port in_valid, input, 1, asserted when the source presents an operation.
REQ-005 The block SHALL have port in_ready, output, 1, asserted when the block can accept an operation.
REQ-006 The block SHALL have port a, input, WIDTH, operand A.
REQ-007 The block SHALL have port b, input, WIDTH, operand B.
REQ-008 The block SHALL have port op, input, 2, the operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-009 The block SHALL have port out_valid, output, 1, asserted when result is valid.
REQ-010 The block SHALL have port out_ready, input, 1, asserted when the sink accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH, the head result.
REQ-012 The block SHALL have port zero, output, 1, set when out_valid is 1 and result equals all-zeros.

Function
REQ-013 An input transfer SHALL occur in a cycle where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-014 Each input transfer SHALL compute op(a,b) bitwise across all WIDTH bits and push it into a 2-entry in-order result queue.
REQ-015 Latency SHALL be 1 cycle: a result accepted at edge N SHALL be presented (out_valid=1) in the cycle after edge N when the queue was empty.
REQ-016 in_ready SHALL equal (count < 2) and be driven from registered state only, with no combinational path from out_ready or in_valid.
REQ-017 Queue count SHALL update as follows: push only gives +1; pop only gives -1; simultaneous push and pop leaves count unchanged, and the popped entry is the older one.
REQ-018 With count 1 and both handshakes active every cycle, the block SHALL sustain one result per cycle.
REQ-019 At count 2, in_ready SHALL be 0 and in_valid SHALL be ignored; at count 0, out_ready SHALL be ignored.
REQ-020 result and zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 result SHALL be all-zeros and zero SHALL be 0 whenever out_valid=0.
REQ-022 Queue read and write pointers SHALL be 1 bit each and wrap from 1 to 0.
REQ-023 Results SHALL leave the block in exactly the order they were accepted, with none lost or duplicated.

Reset
REQ-024 While reset=1 at a rising edge, count, read pointer and write pointer SHALL clear to 0, giving out_valid=0, result=0, zero=0 and in_ready=1 in the following cycle.
REQ-025 Reset SHALL take priority over any simultaneous handshake, so no transfer is recorded in that cycle.
REQ-026 Reset asserted mid-stream SHALL discard all queued results.
REQ-027 Queue storage SHALL NOT require reset.

Structure
REQ-028 The op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the queue depth constant 2 SHALL live in the shared package logic_unit_pkg.
REQ-029 The combinational bitwise operation SHALL be the sub-module bitwise_op (WIDTH parameter; ports a, b, op, y).
REQ-030 The queue and its control SHALL be implemented inside logic_unit_pipe.

Verification (WIDTH=32)
REQ-031 Single op: a=F0F0F0F0, b=0FF00FF0, op=01, out_ready=1 -> next cycle out_valid=1, result=FFF0FFF0, zero=0.
REQ-032 All ops: a=FFFF0000, b=FF00FF00 with op 00/01/10/11 back-to-back, out_ready=1 -> results FF000000, FFFFFF00, 00FFFF00, 000000FF in consecutive cycles.
REQ-033 Zero flag: a=12345678, b=12345678, op=10 -> result=00000000, zero=1.
REQ-034 Backpressure: out_ready=0 with 3 ops offered (AND, OR, XOR of 1,3) -> in_ready drops after 2 accepts; with out_ready then 1 -> 00000001, 00000003, 00000002 in order, and the third is accepted after the first pop.
REQ-035 Reset mid-stream: 2 results queued, reset=1 for one edge -> out_valid=0, in_ready=1, and no stale result appears afterward.
REQ-036 Random stress: 10k random ops with random in_valid/out_ready -> output stream matches the reference-model queue and no in_ready=1 occurs at count 2.
